// File: rtl/frame_timer_pkg.sv
// frame_timer_pkg: key FSM states, default frame counts and fast-sim override for frame_timer.
// FRAME_TIMER_FAST_SIM_EN selects the short frame counts.
package frame_timer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} key_state_e;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_VSYNC_EDGE = 0;
  localparam int DEF_RST_FRAMES = 4;
  localparam int DEF_BLINK_HALF = 16;
  localparam int DEF_KEY_DELAY  = 30;
  localparam int DEF_KEY_RATE   = 3;
  localparam int DEF_KEY_IDLE   = 60;
  localparam int FAST_SIM_VAL   = 2;
`ifdef FRAME_TIMER_FAST_SIM_EN
  localparam bit FAST_SIM = 1'b1;
`else
  localparam bit FAST_SIM = 1'b0;
`endif
endpackage

// File: rtl/frame_edge_det.sv
// frame_edge_det: registers vsync, selects the active edge and emits a registered one-cycle frame tick.
`ifndef DELAY
`define DELAY
`endif
module frame_edge_det
  import frame_timer_pkg::*;
#(
  parameter int VSYNC_EDGE = DEF_VSYNC_EDGE
) (
  input  logic clk,
  input  logic resetn,
  input  logic vsync_i,
  output logic tick_o
);
  logic vs_prev_q, tick_q, edge_det;
  assign edge_det = (VSYNC_EDGE != 0) ? (~vs_prev_q & vsync_i) : (vs_prev_q & ~vsync_i);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vs_prev_q <= `DELAY 1'b0;
      tick_q    <= `DELAY 1'b0;
    end else begin
      vs_prev_q <= `DELAY vsync_i;
      tick_q    <= `DELAY edge_det;
    end
  end
  assign tick_o = tick_q;
endmodule

// File: rtl/frame_timer.sv
// frame_timer: vsync-driven power-up release, cursor blink, typematic repeat and idle key timeout.
// FRAME_TIMER_FAST_SIM_EN releases userResetn immediately and shrinks all frame counts to 2.
`ifndef DELAY
`define DELAY
`endif
module frame_timer
  import frame_timer_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int VSYNC_EDGE = DEF_VSYNC_EDGE,
  parameter int RST_FRAMES = DEF_RST_FRAMES,
  parameter int BLINK_HALF = DEF_BLINK_HALF,
  parameter int KEY_DELAY  = DEF_KEY_DELAY,
  parameter int KEY_RATE   = DEF_KEY_RATE,
  parameter int KEY_IDLE   = DEF_KEY_IDLE
) (
  input  logic clk,
  input  logic resetn,
  input  logic vsync,
  input  logic keyDown,
  input  logic cursorRestart,
  output logic userResetn,
  output logic frameTick,
  output logic cursorBlink,
  output logic keyRepeat,
  output logic keyTimeout
);
  localparam logic [CNT_W-1:0] RF = CNT_W'(RST_FRAMES);
  localparam logic [CNT_W-1:0] BH = CNT_W'(FAST_SIM ? FAST_SIM_VAL : BLINK_HALF);
  localparam logic [CNT_W-1:0] KD = CNT_W'(FAST_SIM ? FAST_SIM_VAL : KEY_DELAY);
  localparam logic [CNT_W-1:0] KR = CNT_W'(FAST_SIM ? FAST_SIM_VAL : KEY_RATE);
  localparam logic [CNT_W-1:0] KI = CNT_W'(FAST_SIM ? FAST_SIM_VAL : KEY_IDLE);
  logic tick, key_rise, key_hit, blink_wrap;
  logic usr_q, usr_d, blink_q, blink_d, rep_q, rep_d, key_prev_q;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d, blink_cnt_q, blink_cnt_d;
  logic [CNT_W-1:0] key_cnt_q, key_cnt_d, idle_cnt_q, idle_cnt_d, key_inc;
  key_state_e key_st_q, key_st_d;
  frame_edge_det #(.VSYNC_EDGE(VSYNC_EDGE)) u_edge (
    .clk(clk),
    .resetn(resetn),
    .vsync_i(vsync),
    .tick_o(tick)
  );
  assign key_rise   = keyDown & ~key_prev_q;
  assign key_inc    = key_cnt_q + 1'b1;
  assign key_hit    = key_inc == ((key_st_q == DELAY) ? KD : KR);
  assign blink_wrap = tick && blink_cnt_q == BH - 1'b1;
  always_comb begin
    usr_d       = FAST_SIM ? 1'b1 : usr_q | (tick & (rst_cnt_q + 1'b1 == RF));
    rst_cnt_d   = (!usr_q && tick) ? rst_cnt_q + 1'b1 : rst_cnt_q;
    blink_cnt_d = (cursorRestart || blink_wrap) ? '0 : blink_cnt_q + CNT_W'(tick);
    blink_d     = cursorRestart ? 1'b1 : blink_q ^ blink_wrap;
    idle_cnt_d  = keyDown ? '0 : (tick && idle_cnt_q != KI) ? idle_cnt_q + 1'b1 : idle_cnt_q;
    key_st_d    = key_st_q;
    key_cnt_d   = key_cnt_q;
    rep_d       = 1'b0;
    // a release beats a coincident tick; a rise ignores one
    case (key_st_q)
      IDLE: begin
        key_st_d  = key_rise ? DELAY : IDLE;
        key_cnt_d = key_rise ? '0 : key_cnt_q;
      end
      DELAY, REPEAT: begin
        if (!keyDown) key_st_d = IDLE;
        else if (tick) begin
          key_cnt_d = key_hit ? '0 : key_inc;
          rep_d     = key_hit;
          key_st_d  = key_hit ? REPEAT : key_st_q;
        end
      end
      default: key_st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      usr_q      <= `DELAY 1'b0;
      rst_cnt_q  <= `DELAY '0;
      key_prev_q <= `DELAY 1'b0;
    end else begin
      usr_q      <= `DELAY usr_d;
      rst_cnt_q  <= `DELAY rst_cnt_d;
      key_prev_q <= `DELAY keyDown;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn || !usr_q) begin
      blink_cnt_q <= `DELAY '0;
      blink_q     <= `DELAY 1'b1;
      key_st_q    <= `DELAY IDLE;
      key_cnt_q   <= `DELAY '0;
      rep_q       <= `DELAY 1'b0;
      idle_cnt_q  <= `DELAY '0;
    end else begin
      blink_cnt_q <= `DELAY blink_cnt_d;
      blink_q     <= `DELAY blink_d;
      key_st_q    <= `DELAY key_st_d;
      key_cnt_q   <= `DELAY key_cnt_d;
      rep_q       <= `DELAY rep_d;
      idle_cnt_q  <= `DELAY idle_cnt_d;
    end
  end
  assign userResetn  = usr_q;
  assign frameTick   = tick;
  assign cursorBlink = blink_q;
  assign keyRepeat   = rep_q;
  assign keyTimeout  = idle_cnt_q == KI;
endmodule

// File: doc/frame_timer.md
Name: frame_timer

Overview:
Parametrised frame-rate timing block for the VGA mini-keyboard terminal. It counts vsync edges and generates the following from them:
- a sticky power-up user reset release;
- a phase-restartable cursor blink;
- a typematic key-repeat state machine;
- an idle key-timeout flag.

It sits between the VGA timing generator (vsync source) and the keyboard scanner / text renderer.

Parameters:
- CNT_W, 8: width of every frame counter; all frame-count parameters must be < 2**CNT_W.
- VSYNC_EDGE, 0: frame edge select; 0 = falling edge of vsync, 1 = rising edge.
- RST_FRAMES, 4: frames after resetn deassertion before userResetn rises (legal range 1..2**CNT_W-1).
- BLINK_HALF, 16: frames per cursor blink half-period (≥1).
- KEY_DELAY, 30: frames from key press to first repeat (≥1).
- KEY_RATE, 3: frames between subsequent repeats (≥1).
- KEY_IDLE, 60: frames with no key held before keyTimeout asserts (≥1).

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- vsync  in  1  vsync from timing generator, synchronous to clk
- keyDown  in  1  level; a key is currently held
- cursorRestart  in  1  one-cycle pulse; force cursor visible and restart blink phase
- userResetn  out  1  held low after reset, rises after RST_FRAMES frames, then stays high until next resetn
- frameTick  out  1  one-cycle pulse per detected frame edge
- cursorBlink  out  1  1 = cursor visible
- keyRepeat  out  1  one-cycle pulse per typematic repeat
- keyTimeout  out  1  level; no key held for KEY_IDLE frames

Behaviour:
- Reset (resetn = 0 at posedge clk) values:
  - userResetn = 0, frameTick = 0, cursorBlink = 1, keyRepeat = 0, keyTimeout = 0.
  - All counters = 0, key FSM = IDLE.
  - vsync history register = 0 and keyDown history register = 0.
  - Reset mid-operation aborts everything and restarts the power-up sequence.
- Edge detect:
  - vsync is registered once (vsPrev).
  - VSYNC_EDGE = 0: edge = vsPrev & ~vsync. VSYNC_EDGE = 1: edge = ~vsPrev & vsync.
  - frameTick is registered: it asserts the cycle after the edge cycle, for exactly one cycle.
  - A vsync held constant produces no ticks.
- Reset release:
  - rstCnt increments on each frameTick while userResetn = 0.
  - When the tick would bring rstCnt to RST_FRAMES, userResetn rises on that same cycle's clock edge.
  - userResetn is sticky and rstCnt freezes.
- Gating: blink, key FSM and idle counter hold their reset values while userResetn = 0. keyDown history keeps tracking.
- Cursor blink:
  - blinkCnt counts frameTicks. When it reaches BLINK_HALF-1 on a tick, it wraps to 0 and cursorBlink toggles.
  - cursorRestart: blinkCnt = 0 and cursorBlink = 1 next cycle. It has priority over a coincident tick.
- Key FSM (states IDLE, DELAY, REPEAT; keyRise = keyDown & ~keyPrev):
  - IDLE: on keyRise → DELAY, keyCnt = 0.
  - DELAY: each tick increments keyCnt. When the tick makes keyCnt reach KEY_DELAY → REPEAT, keyRepeat pulse, keyCnt = 0.
  - REPEAT: when the tick makes keyCnt reach KEY_RATE → keyRepeat pulse, keyCnt = 0.
  - In DELAY or REPEAT, keyDown = 0 → IDLE with no pulse. This takes priority over a coincident tick.
  - A keyRise coinciding with a tick does not count that tick.
  - keyRepeat is never asserted on two consecutive cycles.
- Idle timeout:
  - idleCnt = 0 whenever keyDown = 1, and keyTimeout clears the next cycle.
  - Otherwise idleCnt increments on tick and saturates at KEY_IDLE.
  - keyTimeout = 1 when idleCnt == KEY_IDLE.
- Arithmetic: all counters are unsigned CNT_W. Saturation or wrap is only as stated above; there is no silent overflow.

Optional Feature:
- Macro: FRAME_TIMER_FAST_SIM_EN.
- Defined:
  - userResetn follows resetn with one cycle of latency and ignores RST_FRAMES.
  - BLINK_HALF, KEY_DELAY, KEY_RATE and KEY_IDLE are each replaced internally by 2, so simulations need few frames.
- Undefined: the parameter values are used exactly as given.

Decomposition:
- Package frame_timer_pkg holds:
  - the key FSM state typedef (IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2);
  - the default parameter constants;
  - the fast-sim override constant (2).
- `DELAY from vgaminikbd.vh applies to all non-blocking assignments.
- One natural sub-module, frame_edge_det: contains the vsync register, edge select, and registered frameTick. It is parametrised by VSYNC_EDGE.

Test Plan:
1. Power-up, defaults: resetn low 3 cycles then high, 6 vsync falling edges → userResetn stays 0 through 3 frameTicks, is 1 at the 4th tick, and stays 1 after.
2. Blink: after release, 40 frames with no cursorRestart → cursorBlink toggles at ticks 16 and 32 (1→0→1). A cursorRestart at frame 20 → cursorBlink = 1 next cycle, and the next toggle comes 16 ticks later.
3. Typematic: keyDown high for 40 frames → first keyRepeat at tick 30, then at ticks 33, 36 and 39 (4 pulses). keyDown low at frame 35 gives only the pulses at ticks 30 and 33, with the FSM back in IDLE.
4. Idle timeout: keyDown low for 60 ticks → keyTimeout rises at tick 60 and stays high. keyDown pulse of 1 cycle → keyTimeout = 0 next cycle.
5. Coincidence and reset mid-run: keyRise in the same cycle as frameTick → that tick is not counted (first repeat at tick 31 counted from the rise frame). resetn low during REPEAT → all outputs return to reset values next cycle.
6. VSYNC_EDGE = 1 instance: rising edges produce ticks and falling edges do not. FRAME_TIMER_FAST_SIM_EN build → userResetn = 1 one cycle after resetn = 1, and cursorBlink toggles every 2 ticks.
